// File: rtl/extremum_finder.sv
// extremum_finder: scans an inclusive address range of a synchronous-read
// memory and reports the largest (mode=0) or smallest (mode=1) word, unsigned.
// The lowest address wins among equal extrema.
// Optional macro EXTREMUM_INDEX_EN: when defined, result_addr tracks the
// address of the extremum; when undefined, result_addr is tied to 0.
module extremum_finder #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              mode,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] last_addr,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [DATA_W-1:0] result,
  output logic [ADDR_W-1:0] result_addr
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    READ = 3'd1,
    LOAD = 3'd2,
    CMP  = 3'd3,
    NEXT = 3'd4,
    DONE = 3'd5
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] mar;
  logic [DATA_W-1:0] mdr;
  logic [ADDR_W-1:0] last_q;
  logic              mode_q;
  logic              first;
  logic              take;

  // The memory is always addressed by MAR, in every state.
  assign mem_addr = mar;

  // MDR replaces the running extremum on the first element, or when strictly
  // better; ties keep the earlier (lower) address.
  assign take = first || (mode_q ? (mdr < result) : (mdr > result));

  // Scan sequencer with registered outputs.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, matching real flip-flops.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= IDLE;
      mar    <= '0;
      mdr    <= '0;
      last_q <= '0;
      mode_q <= 1'b0;
      first  <= 1'b0;
      result <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      err    <= 1'b0;
      mem_rd <= 1'b0;
    end else begin
      // Strobes default low; only the branches that need them raise them.
      mem_rd <= 1'b0;
      done   <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            mode_q <= mode;
            last_q <= last_addr;
            mar    <= base_addr;
            first  <= 1'b1;
            if (last_addr >= base_addr) begin
              err    <= 1'b0;
              busy   <= 1'b1;
              mem_rd <= 1'b1;
              state  <= READ;
            end else begin
              err    <= 1'b1;
              result <= '0;
              done   <= 1'b1;
              state  <= DONE;
            end
          end
        end
        READ: state <= LOAD;
        LOAD: begin
          mdr   <= mem_rdata;
          state <= CMP;
        end
        CMP: begin
          if (take) begin
            result <= mdr;
            first  <= 1'b0;
          end
          state <= NEXT;
        end
        NEXT: begin
          // Compare before incrementing so MAR never passes last_addr and
          // a scan ending at the top of the map cannot wrap.
          if (mar == last_q) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end else begin
            mar    <= mar + 1'b1;
            mem_rd <= 1'b1;
            state  <= READ;
          end
        end
        DONE: state <= IDLE;
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

`ifdef EXTREMUM_INDEX_EN
  // Index register: follows every result update, cleared on a range error.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      result_addr <= '0;
    end else if (state == IDLE && start && last_addr < base_addr) begin
      result_addr <= '0;
    end else if (state == CMP && take) begin
      result_addr <= mar;
    end
  end
`else
  assign result_addr = '0;
`endif

endmodule

// File: doc/extremum_finder.md
EXTREMUM_FINDER -- requirements
Module: extremum_finder

Interface
REQ-001 Parameter DATA_W, default 8: memory word width in bits.
REQ-002 Parameter ADDR_W, default 8: memory address width in bits.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 reset_n  input  1  reset, asynchronous and active-low.
REQ-005 start  input  1  request a scan; sampled only in IDLE.
REQ-006 mode  input  1  0 = find maximum, 1 = find minimum; latched on start.
REQ-007 base_addr  input  ADDR_W  first address of the scan; latched on start.
REQ-008 last_addr  input  ADDR_W  final address of the scan, inclusive; latched on start.
REQ-009 mem_rd  output  1  synchronous memory read strobe.
REQ-010 mem_addr  output  ADDR_W  memory read address.
REQ-011 mem_rdata  input  DATA_W  read data, valid the cycle after mem_rd.
REQ-012 busy  output  1  high in every state except IDLE and DONE.
REQ-013 done  output  1  one-cycle pulse when the scan completes.
REQ-014 err  output  1  range error flag; valid with done and held until the next start.
REQ-015 result  output  DATA_W  extremum value; held until the next start.
REQ-016 result_addr  output  ADDR_W  address of the extremum; held until the next start.

Function
REQ-017 The block SHALL implement the states IDLE, READ, LOAD, CMP, NEXT and DONE.
REQ-018 In IDLE with start=1, the block SHALL do all of the following:
- latch mode, base_addr and last_addr;
- load the address register (MAR) with base_addr;
- set the first-element flag;
- clear err.
REQ-019 After a start in IDLE, the next state SHALL be READ if last_addr >= base_addr (unsigned); otherwise err=1 and the next state is DONE.
REQ-020 In IDLE with start=1 and last_addr < base_addr, result and result_addr SHALL be cleared to 0.
REQ-021 READ SHALL assert mem_rd=1 with mem_addr=MAR for exactly one cycle, then go to LOAD.
REQ-022 LOAD SHALL capture mem_rdata into the data register (MDR), then go to CMP.
REQ-023 CMP SHALL update result to MDR when the first-element flag is set, or when MDR is strictly greater than result (mode=0) or strictly less than result (mode=1), unsigned compare.
REQ-024 When CMP updates result, it SHALL also clear the first-element flag and perform the REQ-026 action; CMP then goes to NEXT.
REQ-025 Ties SHALL NOT update result or result_addr, so the lowest address among equal extrema is retained.
REQ-026 result_addr SHALL take the value of MAR on each result update (see Configuration).
REQ-027 NEXT SHALL go to DONE if MAR == last_addr; otherwise it SHALL increment MAR and go to READ.
REQ-028 MAR SHALL never be incremented past last_addr, so last_addr = 2^ADDR_W-1 completes without wrap.
REQ-029 DONE SHALL assert done=1 for one cycle and then go to IDLE.
REQ-030 Latency: for N = last_addr-base_addr+1, done SHALL be high in the cycle 4N+1 clock edges after the start sample edge.
REQ-031 For an error scan, done SHALL be high in the cycle immediately after the start sample edge.
REQ-032 start SHALL be ignored in READ, LOAD, CMP, NEXT and DONE.
REQ-033 Changes to mode, base_addr or last_addr during a scan SHALL have no effect.
REQ-034 mem_rd SHALL be 0 in all states except READ.
REQ-035 mem_addr SHALL equal MAR in every state.

Reset
REQ-036 reset_n=0 SHALL immediately set the state to IDLE, set MAR, MDR, result, result_addr, busy, done, err and mem_rd to 0, and clear the first-element flag.
REQ-037 reset_n=0 mid-scan SHALL abort the scan with no done pulse; the next scan requires a new start.

Configuration
REQ-038 With macro EXTREMUM_INDEX_EN defined, result_addr SHALL be tracked as in REQ-026.
REQ-039 Without EXTREMUM_INDEX_EN, result_addr SHALL be constant 0 and no index register SHALL be implemented; all other behaviour is identical.

Verification
REQ-040 Max scan: memory[0..3]={5,9,2,9}, mode=0, base=0, last=3 -> done at cycle 17, result=9, result_addr=1, err=0.
REQ-041 Min scan: same memory, mode=1 -> result=2, result_addr=2; single-element scan base=last=2 -> done at cycle 5, result=2.
REQ-042 Range error: base=5, last=4 -> done at cycle 1, err=1, result=0, result_addr=0, and mem_rd never asserted.
REQ-043 Top-of-map scan: ADDR_W=8, base=254, last=255, memory[255]=0xFF, mode=0 -> result=0xFF, result_addr=255, MAR never wraps to 0.
REQ-044 Reset mid-scan: reset_n=0 in CMP of element 2 -> all outputs 0 asynchronously, no done pulse; a second start with start held during the scan runs to completion exactly once.
REQ-045 Build without EXTREMUM_INDEX_EN: repeat REQ-040 -> result=9, result_addr=0.
